// File: rtl/inagu_nd_pkg.sv
// Shared types and default widths for the nested-loop address generator.
package inagu_nd_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int DefBprec    = 6;
  localparam int DefBdbanka  = 15;
  localparam int DefBwbanka  = 9;
  localparam int DefBwlength = 8;
  localparam int DefNdim     = 3;

endpackage

// File: rtl/agu_loop_nd.sv
// NDIM-deep wrapping loop counter with per-dim stride accumulators.
// Dim 0 steps on i_inc0; dims 1..NDIM-1 form a carry chain stepped by i_inc_outer.
module agu_loop_nd
  import inagu_nd_pkg::*;
#(
  parameter int NDIM  = DefNdim,
  parameter int BADDR = DefBdbanka,
  parameter int BLEN  = DefBwlength
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic                  i_inc0,
  input  logic                  i_inc_outer,
  input  logic [NDIM*BLEN-1:0]  i_length,
  input  logic [NDIM*BADDR-1:0] i_stride,
  output logic [BADDR-1:0]      o_offset,
  output logic [NDIM-1:0]       o_last,
  output logic                  o_first0
);

  logic [BLEN-1:0]  r_idx [NDIM];
  logic [BADDR-1:0] r_acc [NDIM];
  logic [NDIM-1:0]  w_step;
  logic             w_carry;

  always_comb begin
    o_last   = '0;
    o_offset = '0;
    for (int k = 0; k < NDIM; k++) begin
      o_last[k] = (r_idx[k] == i_length[k*BLEN +: BLEN]);
      o_offset  = o_offset + r_acc[k];
    end
    o_first0 = (r_idx[0] == '0);
  end

  always_comb begin
    w_step    = '0;
    w_step[0] = i_inc0;
    w_carry   = i_inc_outer;
    for (int k = 1; k < NDIM; k++) begin
      w_step[k] = w_carry;
      w_carry   = w_carry & o_last[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NDIM; k++) begin
        r_idx[k] <= '0;
        r_acc[k] <= '0;
      end
    end else if (i_load) begin
      for (int k = 0; k < NDIM; k++) begin
        r_idx[k] <= '0;
        r_acc[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NDIM; k++) begin
        if (w_step[k]) begin
          if (o_last[k]) begin
            r_idx[k] <= '0;
            r_acc[k] <= '0;
          end else begin
            r_idx[k] <= r_idx[k] + 1'b1;
            r_acc[k] <= r_acc[k] + i_stride[k*BADDR +: BADDR];
          end
        end
      end
    end
  end

endmodule

// File: rtl/inagu_nd.sv
// Bit-serial input/weight address generator: dim-0 loop inside a zig-zag over
// (weight, data) bit-plane pairs, inside the remaining element loops.
module inagu_nd
  import inagu_nd_pkg::*;
#(
  parameter int BPREC    = DefBprec,
  parameter int BDBANKA  = DefBdbanka,
  parameter int BWBANKA  = DefBwbanka,
  parameter int BWLENGTH = DefBwlength,
  parameter int NDIM     = DefNdim
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     ready,
  input  logic [BPREC-1:0]         iprecision,
  input  logic [BPREC-1:0]         wprecision,
  input  logic [NDIM*BDBANKA-1:0]  istride,
  input  logic [NDIM*BWBANKA-1:0]  wstride,
  input  logic [NDIM*BWLENGTH-1:0] ilength,
  input  logic [NDIM*BWLENGTH-1:0] wlength,
  input  logic [BDBANKA-1:0]       ibaseaddr,
  input  logic [BWBANKA-1:0]       wbaseaddr,
  output logic                     valid,
  output logic [BDBANKA-1:0]       iaddr_out,
  output logic [BWBANKA-1:0]       waddr_out,
  output logic                     sh_out,
  output logic                     shacc_done,
  output logic                     busy,
  output logic                     done
);

  state_e r_state, w_state_next;

  logic [BPREC-1:0]         r_pw, r_pd, r_w, r_d, w_w_next, w_d_next, w_pw_in, w_pd_in;
  logic [NDIM*BDBANKA-1:0]  r_istride;
  logic [NDIM*BWBANKA-1:0]  r_wstride;
  logic [NDIM*BWLENGTH-1:0] r_wlen;
  logic [BDBANKA-1:0]       r_ibase, w_ioff;
  logic [BWBANKA-1:0]       r_wbase, w_woff;
  logic [NDIM-1:0]          w_ilast, w_wlast, w_last;
  logic [BPREC:0]           w_s1, w_pdm1;
  logic w_launch, w_xfer, w_zz_last, w_zz_inner, w_zz_top, w_inc_outer, w_final;
  logic w_ifirst0, w_wfirst0, w_unused;

  // Data loop wraps on wlength; ilength is accepted on the interface only.
  assign w_unused = ^ilength;

  assign valid    = (r_state == StRun);
  assign busy     = (r_state != StIdle);
  assign done     = (r_state == StDone);
  assign w_xfer   = valid & ready;
  assign w_launch = (r_state == StIdle) & start & ~clr;
  assign w_pw_in  = (wprecision == '0) ? BPREC'(1) : wprecision;
  assign w_pd_in  = (iprecision == '0) ? BPREC'(1) : iprecision;

  // Both loops share wlength, so their wrap flags are identical.
  assign w_last      = w_ilast & w_wlast;
  assign w_zz_last   = (r_w == '0) && (r_d == '0);
  assign w_zz_top    = (r_w == r_pw - 1'b1) && (r_d == r_pd - 1'b1);
  assign w_zz_inner  = (r_w != r_pw - 1'b1) && (r_d != '0);
  assign w_inc_outer = w_xfer & w_last[0] & w_zz_last;
  assign w_final     = w_inc_outer & (&w_last[NDIM-1:1]);

  assign w_s1   = {1'b0, r_w} + {1'b0, r_d} - 1'b1;
  assign w_pdm1 = {1'b0, r_pd - 1'b1};

  // Next pair: step along the current diagonal, else start the next lower one.
  always_comb begin
    w_w_next = r_w + 1'b1;
    w_d_next = r_d - 1'b1;
    if (!w_zz_inner) begin
      if (w_s1 >= w_pdm1) begin
        w_w_next = BPREC'(w_s1 - w_pdm1);
        w_d_next = r_pd - 1'b1;
      end else begin
        w_w_next = '0;
        w_d_next = w_s1[BPREC-1:0];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clr) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (start) w_state_next = StRun;
        StRun:   if (w_final) w_state_next = StDone;
        StDone:  w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_pw      <= '0;
      r_pd      <= '0;
      r_w       <= '0;
      r_d       <= '0;
      r_istride <= '0;
      r_wstride <= '0;
      r_wlen    <= '0;
      r_ibase   <= '0;
      r_wbase   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_launch) begin
        r_pw      <= w_pw_in;
        r_pd      <= w_pd_in;
        r_w       <= w_pw_in - 1'b1;
        r_d       <= w_pd_in - 1'b1;
        r_istride <= istride;
        r_wstride <= wstride;
        r_wlen    <= wlength;
        r_ibase   <= ibaseaddr;
        r_wbase   <= wbaseaddr;
      end else if (w_xfer && w_last[0]) begin
        r_w <= w_zz_last ? r_pw - 1'b1 : w_w_next;
        r_d <= w_zz_last ? r_pd - 1'b1 : w_d_next;
      end
    end
  end

  agu_loop_nd #(
    .NDIM (NDIM),
    .BADDR(BDBANKA),
    .BLEN (BWLENGTH)
  ) u_iloop (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_launch),
    .i_inc0     (w_xfer),
    .i_inc_outer(w_inc_outer),
    .i_length   (r_wlen),
    .i_stride   (r_istride),
    .o_offset   (w_ioff),
    .o_last     (w_ilast),
    .o_first0   (w_ifirst0)
  );

  agu_loop_nd #(
    .NDIM (NDIM),
    .BADDR(BWBANKA),
    .BLEN (BWLENGTH)
  ) u_wloop (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_launch),
    .i_inc0     (w_xfer),
    .i_inc_outer(w_inc_outer),
    .i_length   (r_wlen),
    .i_stride   (r_wstride),
    .o_offset   (w_woff),
    .o_last     (w_wlast),
    .o_first0   (w_wfirst0)
  );

  assign iaddr_out  = r_ibase + w_ioff + BDBANKA'(r_d);
  assign waddr_out  = r_wbase + w_woff + BWBANKA'(r_w);
  // First beat of a diagonal is the pair with d at its top or w at zero.
  assign sh_out     = valid & w_ifirst0 & w_wfirst0 & ((r_d == r_pd - 1'b1) | (r_w == '0))
                      & ~w_zz_top;
  assign shacc_done = valid & w_last[0] & w_zz_last;

endmodule

// File: tb/tb_inagu_nd.sv
// Randomized and directed checks of inagu_nd against a nested-loop reference model.
module tb_inagu_nd;

  localparam int NDIM = 3;
  localparam int BD   = 15;
  localparam int BW   = 9;
  localparam int BL   = 8;
  localparam int BP   = 6;

  logic clk, rst_n, clr, start, ready;
  logic [BP-1:0]      iprecision, wprecision;
  logic [NDIM*BD-1:0] istride;
  logic [NDIM*BW-1:0] wstride;
  logic [NDIM*BL-1:0] ilength, wlength;
  logic [BD-1:0]      ibaseaddr, iaddr_out;
  logic [BW-1:0]      wbaseaddr, waddr_out;
  logic valid, sh_out, shacc_done, busy, done;

  inagu_nd #(
    .BPREC   (BP),
    .BDBANKA (BD),
    .BWBANKA (BW),
    .BWLENGTH(BL),
    .NDIM    (NDIM)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .start     (start),
    .ready     (ready),
    .iprecision(iprecision),
    .wprecision(wprecision),
    .istride   (istride),
    .wstride   (wstride),
    .ilength   (ilength),
    .wlength   (wlength),
    .ibaseaddr (ibaseaddr),
    .wbaseaddr (wbaseaddr),
    .valid     (valid),
    .iaddr_out (iaddr_out),
    .waddr_out (waddr_out),
    .sh_out    (sh_out),
    .shacc_done(shacc_done),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ia;
    int wa;
    int sh;
    int acc;
  } beat_t;

  beat_t exp_q[$];
  int obs_ia[$], obs_wa[$], obs_sh[$], obs_acc[$];
  int n_checks, n_errors;

  int c_ipr, c_wpr, c_ibase, c_wbase;
  int c_istr[NDIM], c_wstr[NDIM], c_wlen[NDIM];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive_cfg();
    iprecision = BP'(c_ipr);
    wprecision = BP'(c_wpr);
    ibaseaddr  = BD'(c_ibase);
    wbaseaddr  = BW'(c_wbase);
    for (int k = 0; k < NDIM; k++) begin
      istride[k*BD +: BD] = BD'(c_istr[k]);
      wstride[k*BW +: BW] = BW'(c_wstr[k]);
      wlength[k*BL +: BL] = BL'(c_wlen[k]);
      ilength[k*BL +: BL] = BL'($urandom);
    end
  endtask

  // Expected beat list straight from the loop-nest description.
  function automatic void build_model();
    int pw, pd, top_s, n_outer;
    exp_q.delete();
    pw      = (c_wpr == 0) ? 1 : c_wpr;
    pd      = (c_ipr == 0) ? 1 : c_ipr;
    top_s   = pw + pd - 2;
    n_outer = 1;
    for (int k = 1; k < NDIM; k++) n_outer *= c_wlen[k] + 1;
    for (int o = 0; o < n_outer; o++) begin
      int idx[NDIM];
      int rem;
      rem = o;
      for (int k = 1; k < NDIM; k++) begin
        idx[k] = rem % (c_wlen[k] + 1);
        rem    = rem / (c_wlen[k] + 1);
      end
      for (int s = top_s; s >= 0; s--) begin
        bit first;
        first = 1'b1;
        for (int w = 0; w < pw; w++) begin
          int d;
          d = s - w;
          if (d >= 0 && d < pd) begin
            for (int i0 = 0; i0 <= c_wlen[0]; i0++) begin
              int ioff, woff;
              beat_t b;
              idx[0] = i0;
              ioff   = 0;
              woff   = 0;
              for (int k = 0; k < NDIM; k++) begin
                ioff += idx[k] * c_istr[k];
                woff += idx[k] * c_wstr[k];
              end
              b.ia  = (c_ibase + ioff + d) & 'h7fff;
              b.wa  = (c_wbase + woff + w) & 'h1ff;
              b.sh  = (i0 == 0 && first && s != top_s) ? 1 : 0;
              b.acc = (i0 == c_wlen[0] && s == 0) ? 1 : 0;
              exp_q.push_back(b);
            end
            first = 1'b0;
          end
        end
      end
    end
  endfunction

  // mode 0: ready high; 1: random; 2: repeating 1,0,0,1. poke: start/config noise while busy.
  task automatic run_txn(input int mode, input bit poke);
    int cyc;
    bit r;
    drive_cfg();
    build_model();
    obs_ia.delete();
    obs_wa.delete();
    obs_sh.delete();
    obs_acc.delete();
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("latency_valid", int'(valid), 1);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      ready = r;
      if (poke) begin
        start     = ($urandom_range(0, 3) == 0);
        ibaseaddr = BD'($urandom);
      end
      check("valid", int'(valid), 1);
      check("iaddr", int'(iaddr_out), exp_q[0].ia);
      check("waddr", int'(waddr_out), exp_q[0].wa);
      check("sh_out", int'(sh_out), exp_q[0].sh);
      check("shacc_done", int'(shacc_done), exp_q[0].acc);
      if (r) begin
        obs_ia.push_back(int'(iaddr_out));
        obs_wa.push_back(int'(waddr_out));
        obs_sh.push_back(int'(sh_out));
        obs_acc.push_back(int'(shacc_done));
        void'(exp_q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    check("beats_left", exp_q.size(), 0);
    check("done_pulse", int'(done), 1);
    check("valid_in_done", int'(valid), 0);
    check("busy_in_done", int'(busy), 1);
    @(negedge clk);
    check("done_cleared", int'(done), 0);
    check("busy_idle", int'(busy), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_sh"}, int'(sh_out), 0);
    check({tag, "_acc"}, int'(shacc_done), 0);
    check({tag, "_iaddr"}, int'(iaddr_out), 0);
    check({tag, "_waddr"}, int'(waddr_out), 0);
  endtask

  task automatic set_simple(input int len0, input int ibase, input int istr0);
    c_ipr   = 1;
    c_wpr   = 1;
    c_ibase = ibase;
    c_wbase = 0;
    c_istr  = '{istr0, 0, 0};
    c_wstr  = '{1, 0, 0};
    c_wlen  = '{len0, 0, 0};
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    iprecision = '0;
    wprecision = '0;
    istride = '0;
    wstride = '0;
    ilength = '0;
    wlength = '0;
    ibaseaddr = '0;
    wbaseaddr = '0;
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Two beats, stride 2.
    c_ipr = 1; c_wpr = 1; c_ibase = 'h10; c_wbase = 'h4;
    c_istr = '{2, 0, 0}; c_wstr = '{2, 0, 0}; c_wlen = '{1, 0, 0};
    run_txn(0, 1'b0);
    check("r030_nbeats", obs_ia.size(), 2);
    if (obs_ia.size() == 2) begin
      check("r030_ia0", obs_ia[0], 'h10);
      check("r030_ia1", obs_ia[1], 'h12);
      check("r030_wa0", obs_wa[0], 'h4);
      check("r030_wa1", obs_wa[1], 'h6);
      check("r030_acc0", obs_acc[0], 0);
      check("r030_acc1", obs_acc[1], 1);
    end

    // 2x2 zig-zag: pairs (1,1),(0,1),(1,0),(0,0).
    c_ipr = 2; c_wpr = 2; c_ibase = 0; c_wbase = 0;
    c_istr = '{0, 0, 0}; c_wstr = '{0, 0, 0}; c_wlen = '{0, 0, 0};
    run_txn(0, 1'b0);
    check("r031_nbeats", obs_ia.size(), 4);
    if (obs_ia.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("r031_w", obs_wa[i], (i % 2 == 0) ? 1 : 0);
        check("r031_d", obs_ia[i], (i < 2) ? 1 : 0);
        check("r031_sh", obs_sh[i], (i == 1 || i == 3) ? 1 : 0);
        check("r031_acc", obs_acc[i], (i == 3) ? 1 : 0);
      end
    end

    // Stall pattern on a multi-dim config.
    c_ipr = 2; c_wpr = 3; c_ibase = 'h123; c_wbase = 'h45;
    c_istr = '{3, 100, 1000}; c_wstr = '{5, 17, 60}; c_wlen = '{2, 1, 1};
    run_txn(2, 1'b0);

    // Address wrap.
    set_simple(1, 'h7fff, 1);
    run_txn(0, 1'b0);
    check("r033_nbeats", obs_ia.size(), 2);
    if (obs_ia.size() == 2) begin
      check("r033_ia0", obs_ia[0], 'h7fff);
      check("r033_ia1", obs_ia[1], 'h0000);
    end

    // clr on beat 3 of 8.
    set_simple(7, 'h200, 1);
    drive_cfg();
    build_model();
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("clr_pre_iaddr", int'(iaddr_out), exp_q[0].ia);
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_valid", int'(valid), 0);
    check("clr_busy", int'(busy), 0);
    check("clr_done", int'(done), 0);
    @(negedge clk);
    check("clr_no_done", int'(done), 0);
    run_txn(0, 1'b0);
    check("clr_rerun_nbeats", obs_ia.size(), 8);

    // Asynchronous reset mid-run.
    set_simple(5, 'h55, 2);
    drive_cfg();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_no_done", int'(done), 0);
    check("rst_idle", int'(busy), 0);
    run_txn(0, 1'b0);
    check("rst_rerun_nbeats", obs_ia.size(), 6);

    // Random configurations.
    for (int t = 0; t < 16; t++) begin
      c_ipr   = $urandom_range(0, 3);
      c_wpr   = $urandom_range(0, 3);
      c_ibase = $urandom_range(0, 'h7fff);
      c_wbase = $urandom_range(0, 'h1ff);
      for (int k = 0; k < NDIM; k++) begin
        c_istr[k] = $urandom_range(0, 'h7fff);
        c_wstr[k] = $urandom_range(0, 'h1ff);
        c_wlen[k] = $urandom_range(0, 2);
      end
      run_txn($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
